// File: rtl/countdown_display.sv
// rtl/countdown_display.sv - per-street phase countdowns shown on a 4-digit multiplexed 7-segment display
`timescale 1ns/1ps

module countdown_channel #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int GREEN_SEC  = 25,
  parameter int YELLOW_SEC = 3,
  parameter int RED_SEC    = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] code,
  input  logic       pri_lamp,
  output logic [6:0] cnt,
  output logic       valid,
  output logic       pri
);
  localparam int SUB_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICK_DIV - 1);

  logic [2:0]       prev;
  logic [SUB_W-1:0] sub;
  logic             one_hot;
  logic [6:0]       duration;

  always_comb begin
    one_hot = (code == 3'b001) || (code == 3'b010) || (code == 3'b100);
    case (code)
      3'b001:  duration = 7'(GREEN_SEC);
      3'b010:  duration = 7'(YELLOW_SEC);
      3'b100:  duration = 7'(RED_SEC);
      default: duration = 7'd0;
    endcase
  end

  // A load or an invalid code takes priority over the freeze and over a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 3'b000;
      cnt   <= 7'd0;
      sub   <= '0;
      valid <= 1'b0;
      pri   <= 1'b0;
    end else begin
      pri <= pri_lamp;
      if (one_hot && (code != prev)) begin
        prev  <= code;
        cnt   <= duration;
        sub   <= '0;
        valid <= 1'b1;
      end else if (!one_hot) begin
        prev  <= code;
        cnt   <= 7'd0;
        sub   <= '0;
        valid <= 1'b0;
      end else if (!pri_lamp) begin
        if (sub == SUB_LAST) begin
          sub <= '0;
          if (cnt != 7'd0) cnt <= cnt - 7'd1;
        end else begin
          sub <= sub + 1'b1;
        end
      end
    end
  end
endmodule

module countdown_display #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int SCAN_DIV   = 50_000,
  parameter int GREEN_SEC  = 25,
  parameter int YELLOW_SEC = 3,
  parameter int RED_SEC    = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] street_a,
  input  logic       street_a_pri_lamp,
  input  logic [2:0] street_b,
  input  logic       street_b_pri_lamp,
  output logic [6:0] count_a,
  output logic [6:0] count_b,
  output logic [6:0] seg,
  output logic [3:0] an
);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  logic [6:0]        cnt_a, cnt_b;
  logic              valid_a, valid_b, pri_a, pri_b;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        scan_idx;
  logic [6:0]        sel_cnt, tens_val, units_val, digit_seg;
  logic              sel_valid, sel_pri;

  countdown_channel #(
    .TICK_DIV(TICK_DIV), .GREEN_SEC(GREEN_SEC), .YELLOW_SEC(YELLOW_SEC), .RED_SEC(RED_SEC)
  ) u_chan_a (
    .clk(clk), .rst_n(rst_n), .code(street_a), .pri_lamp(street_a_pri_lamp),
    .cnt(cnt_a), .valid(valid_a), .pri(pri_a)
  );

  countdown_channel #(
    .TICK_DIV(TICK_DIV), .GREEN_SEC(GREEN_SEC), .YELLOW_SEC(YELLOW_SEC), .RED_SEC(RED_SEC)
  ) u_chan_b (
    .clk(clk), .rst_n(rst_n), .code(street_b), .pri_lamp(street_b_pri_lamp),
    .cnt(cnt_b), .valid(valid_b), .pri(pri_b)
  );

  assign count_a = cnt_a;
  assign count_b = cnt_b;

  function automatic logic [6:0] glyph(input logic [6:0] d);
    case (d)
      7'd0:    glyph = 7'h40;
      7'd1:    glyph = 7'h79;
      7'd2:    glyph = 7'h24;
      7'd3:    glyph = 7'h30;
      7'd4:    glyph = 7'h19;
      7'd5:    glyph = 7'h12;
      7'd6:    glyph = 7'h02;
      7'd7:    glyph = 7'h78;
      7'd8:    glyph = 7'h00;
      7'd9:    glyph = 7'h10;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Index bit 1 selects the street, bit 0 selects tens over units.
  always_comb begin
    sel_cnt   = scan_idx[1] ? cnt_b   : cnt_a;
    sel_valid = scan_idx[1] ? valid_b : valid_a;
    sel_pri   = scan_idx[1] ? pri_b   : pri_a;
    tens_val  = sel_cnt / 7'd10;
    units_val = sel_cnt % 7'd10;
    if (!sel_valid)
      digit_seg = SEG_BLANK;
    else if (sel_pri)
      digit_seg = SEG_DASH;
    else if (scan_idx[0])
      digit_seg = (sel_cnt < 7'd10) ? SEG_BLANK : glyph(tens_val);
    else
      digit_seg = glyph(units_val);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= 4'b1110;
    end else begin
      seg <= digit_seg;
      an  <= ~(4'b0001 << scan_idx);
    end
  end
endmodule
